// File: rtl/sdram_avalon_arbiter.sv
// Round-robin two-master Avalon-MM arbiter for one SDRAM slave. It adds zero cycles, and the grant holds while s_waitrequest stalls.
// Backpressure: a master is stalled when not granted, when the slave stalls, or when it reads while the tag FIFO is full and nothing pops.
module sdram_avalon_arbiter #(
    parameter int ADDR_W   = 25,
    parameter int DATA_W   = 16,
    parameter int BE_W     = 2,
    parameter int MAX_PEND = 4
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    input  logic [BE_W-1:0]   m0_byteenable,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    input  logic [BE_W-1:0]   m1_byteenable,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,

    output logic [ADDR_W-1:0] s_address,
    output logic              s_read,
    output logic              s_write,
    output logic [DATA_W-1:0] s_writedata,
    output logic [BE_W-1:0]   s_byteenable,
    input  logic              s_waitrequest,
    input  logic [DATA_W-1:0] s_readdata,
    input  logic              s_readdatavalid,

    output logic              err_orphan
);

    localparam int PTR_W = $clog2(MAX_PEND);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_PEND);

    typedef enum logic {ST_ARB, ST_HOLD} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_gnt;
    logic                r_rr_ptr;
    logic [MAX_PEND-1:0] r_tag;
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;
    logic                r_err_orphan;

    logic w_gnt;
    logic w_gnt_vld;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_rd_ok;
    logic w_req0;
    logic w_req1;
    logic w_sel_read;
    logic w_accept;
    logic w_head;

    assign w_full  = (r_count == FULL_CNT);
    assign w_pop   = s_readdatavalid && (r_count != '0);
    // A full FIFO still takes a read when a return frees a slot in the same cycle.
    assign w_rd_ok = !w_full || w_pop;
    assign w_req0  = m0_write || (m0_read && w_rd_ok);
    assign w_req1  = m1_write || (m1_read && w_rd_ok);

    always_comb begin
        w_state_nxt = r_state;
        w_gnt       = r_rr_ptr;
        w_gnt_vld   = 1'b0;
        case (r_state)
            ST_ARB: begin
                if (w_req0 && w_req1) begin
                    w_gnt     = r_rr_ptr;
                    w_gnt_vld = 1'b1;
                end else if (w_req0) begin
                    w_gnt     = 1'b0;
                    w_gnt_vld = 1'b1;
                end else if (w_req1) begin
                    w_gnt     = 1'b1;
                    w_gnt_vld = 1'b1;
                end
                if (w_gnt_vld && s_waitrequest) begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                w_gnt     = r_gnt;
                w_gnt_vld = 1'b1;
                if (!s_waitrequest) begin
                    w_state_nxt = ST_ARB;
                end
            end
            default: w_state_nxt = ST_ARB;
        endcase
    end

    assign w_sel_read   = w_gnt ? m1_read : m0_read;
    assign s_read       = w_gnt_vld && w_sel_read;
    assign s_write      = w_gnt_vld && (w_gnt ? m1_write : m0_write);
    assign s_address    = w_gnt ? m1_address    : m0_address;
    assign s_writedata  = w_gnt ? m1_writedata  : m0_writedata;
    assign s_byteenable = w_gnt ? m1_byteenable : m0_byteenable;

    assign w_accept       = w_gnt_vld && !s_waitrequest;
    assign w_push         = w_accept && w_sel_read;
    assign m0_waitrequest = !(w_accept && !w_gnt);
    assign m1_waitrequest = !(w_accept && w_gnt);

    assign w_head           = r_tag[r_rd_ptr];
    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;
    assign m0_readdatavalid = w_pop && !w_head;
    assign m1_readdatavalid = w_pop && w_head;
    assign err_orphan       = r_err_orphan;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state  <= ST_ARB;
            r_gnt    <= 1'b0;
            r_rr_ptr <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt;
            if (w_accept) begin
                r_rr_ptr <= !w_gnt;
            end
        end
    end

    // Tag FIFO: one bit per outstanding read naming the issuing master, in issue order.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_tag        <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_err_orphan <= 1'b0;
        end else begin
            if (w_push) begin
                r_tag[r_wr_ptr] <= w_gnt;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (s_readdatavalid && (r_count == '0)) begin
                r_err_orphan <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sdram_avalon_arbiter.sv
// Bench for sdram_avalon_arbiter: per-cycle vector table plus a read-return scoreboard and a hand-written reset sequence.
module tb_sdram_avalon_arbiter;

    localparam logic [24:0] A0  = 25'h10;
    localparam logic [24:0] A1  = 25'h20;
    localparam logic [15:0] WD0 = 16'h1234;
    localparam logic [15:0] WD1 = 16'hBEEF;
    localparam logic [1:0]  BE0 = 2'b01;
    localparam logic [1:0]  BE1 = 2'b10;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n;
    logic [24:0] m0_address, m1_address, s_address;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [15:0] m0_writedata, m1_writedata, s_writedata;
    logic [1:0]  m0_byteenable, m1_byteenable, s_byteenable;
    logic        m0_waitrequest, m1_waitrequest;
    logic [15:0] m0_readdata, m1_readdata, s_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic        s_read, s_write, s_waitrequest, s_readdatavalid;
    logic        err_orphan;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        bit        m0_rd, m0_wr, m1_rd, m1_wr, s_wait, s_rdv;
        bit [15:0] s_rdata;
        bit        e_s_rd, e_s_wr, e_g, e_w0, e_w1, e_err;
    } vec_t;

    vec_t tbl[$];
    bit   sb_q[$];

    sdram_avalon_arbiter dut (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
        .s_readdatavalid(s_readdatavalid), .err_orphan(err_orphan)
    );

    always #5 clk_clk = ~clk_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input bit m0r, m0w, m1r, m1w, sw, rdv, input bit [15:0] d,
                                input bit esr, esw, eg, ew0, ew1, eerr);
        vec_t v;
        v.m0_rd = m0r; v.m0_wr = m0w; v.m1_rd = m1r; v.m1_wr = m1w;
        v.s_wait = sw; v.s_rdv = rdv; v.s_rdata = d;
        v.e_s_rd = esr; v.e_s_wr = esw; v.e_g = eg;
        v.e_w0 = ew0; v.e_w1 = ew1; v.e_err = eerr;
        return v;
    endfunction

    task automatic drive(input bit m0r, m0w, m1r, m1w, sw, rdv, input bit [15:0] d);
        m0_read = m0r; m0_write = m0w; m1_read = m1r; m1_write = m1w;
        s_waitrequest = sw; s_readdatavalid = rdv; s_readdata = d;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, ".s_read"}, s_read, 0);
        chk({tag, ".s_write"}, s_write, 0);
        chk({tag, ".m0_waitrequest"}, m0_waitrequest, 1);
        chk({tag, ".m1_waitrequest"}, m1_waitrequest, 1);
        chk({tag, ".m0_readdatavalid"}, m0_readdatavalid, 0);
        chk({tag, ".m1_readdatavalid"}, m1_readdatavalid, 0);
    endtask

    initial begin
        m0_address = A0; m1_address = A1;
        m0_writedata = WD0; m1_writedata = WD1;
        m0_byteenable = BE0; m1_byteenable = BE1;
        drive(0, 0, 0, 0, 0, 0, 16'h0);
        reset_reset_n = 1'b0;

        // T1 / T2: write from each master, then a simultaneous read pair and its returns.
        tbl.push_back(mk(0,1,0,0,0,0,16'h0000, 0,1,0, 0,1, 0));
        tbl.push_back(mk(0,0,0,1,0,0,16'h0000, 0,1,1, 1,0, 0));
        tbl.push_back(mk(1,0,1,0,0,0,16'h0000, 1,0,0, 0,1, 0));
        tbl.push_back(mk(0,0,1,0,0,0,16'h0000, 1,0,1, 1,0, 0));
        tbl.push_back(mk(0,0,0,0,0,1,16'hAAAA, 0,0,0, 1,1, 0));
        tbl.push_back(mk(0,0,0,0,0,1,16'h5555, 0,0,0, 1,1, 0));
        // T3: m1 write stalled three cycles while m0 also requests.
        tbl.push_back(mk(0,0,0,1,1,0,16'h0000, 0,1,1, 1,1, 0));
        tbl.push_back(mk(0,1,0,1,1,0,16'h0000, 0,1,1, 1,1, 0));
        tbl.push_back(mk(0,1,0,1,1,0,16'h0000, 0,1,1, 1,1, 0));
        tbl.push_back(mk(0,1,0,1,0,0,16'h0000, 0,1,1, 1,0, 0));
        tbl.push_back(mk(0,1,0,0,0,0,16'h0000, 0,1,0, 0,1, 0));
        // T4: fill the tag FIFO, stall the fifth read, then accept it alongside a return.
        for (int k = 0; k < 4; k++) tbl.push_back(mk(1,0,0,0,0,0,16'h0000, 1,0,0, 0,1, 0));
        tbl.push_back(mk(1,0,0,0,0,0,16'h0000, 0,0,0, 1,1, 0));
        tbl.push_back(mk(1,0,0,0,0,1,16'h0001, 1,0,0, 0,1, 0));
        for (int k = 0; k < 4; k++) tbl.push_back(mk(0,0,0,0,0,1,16'(k + 2), 0,0,0, 1,1, 0));
        // T5: orphan return on an empty FIFO; the flag is registered.
        tbl.push_back(mk(0,0,0,0,0,1,16'h0BAD, 0,0,0, 1,1, 0));
        tbl.push_back(mk(0,0,0,0,0,0,16'h0000, 0,0,0, 1,1, 1));
        tbl.push_back(mk(0,0,0,0,0,0,16'h0000, 0,0,0, 1,1, 1));

        repeat (2) @(posedge clk_clk);
        @(negedge clk_clk);
        check_idle("reset");
        chk("reset.err_orphan", err_orphan, 0);
        @(posedge clk_clk); #1 reset_reset_n = 1'b1;

        foreach (tbl[i]) begin
            vec_t v;
            string t;
            v = tbl[i];
            t = $sformatf("v%0d", i);
            @(posedge clk_clk); #1;
            drive(v.m0_rd, v.m0_wr, v.m1_rd, v.m1_wr, v.s_wait, v.s_rdv, v.s_rdata);
            @(negedge clk_clk);
            chk({t, ".s_read"}, s_read, v.e_s_rd);
            chk({t, ".s_write"}, s_write, v.e_s_wr);
            chk({t, ".m0_waitrequest"}, m0_waitrequest, v.e_w0);
            chk({t, ".m1_waitrequest"}, m1_waitrequest, v.e_w1);
            chk({t, ".err_orphan"}, err_orphan, v.e_err);
            if (v.e_s_rd || v.e_s_wr) begin
                chk({t, ".s_address"}, s_address, v.e_g ? A1 : A0);
                chk({t, ".s_writedata"}, s_writedata, v.e_g ? WD1 : WD0);
                chk({t, ".s_byteenable"}, s_byteenable, v.e_g ? BE1 : BE0);
            end
            if (v.s_rdv) begin
                if (sb_q.size() > 0) begin
                    bit owner;
                    owner = sb_q.pop_front();
                    chk({t, ".m0_readdatavalid"}, m0_readdatavalid, !owner);
                    chk({t, ".m1_readdatavalid"}, m1_readdatavalid, owner);
                    chk({t, ".readdata"}, owner ? m1_readdata : m0_readdata, v.s_rdata);
                end else begin
                    chk({t, ".orphan_m0_rdv"}, m0_readdatavalid, 0);
                    chk({t, ".orphan_m1_rdv"}, m1_readdatavalid, 0);
                end
            end else begin
                chk({t, ".m0_readdatavalid"}, m0_readdatavalid, 0);
                chk({t, ".m1_readdatavalid"}, m1_readdatavalid, 0);
            end
            if (v.e_s_rd && !v.s_wait) sb_q.push_back(v.e_g);
        end
        chk("sb.drained", sb_q.size(), 0);

        // T6: reset clears the sticky flag, then a reset with three reads pending orphans their returns.
        @(posedge clk_clk); #1;
        drive(0, 0, 0, 0, 0, 0, 16'h0);
        reset_reset_n = 1'b0;
        @(negedge clk_clk);
        chk("t6.err_cleared", err_orphan, 0);
        @(posedge clk_clk); #1 reset_reset_n = 1'b1;

        for (int k = 0; k < 3; k++) begin
            @(posedge clk_clk); #1;
            drive(k != 1, 0, k == 1, 0, 0, 0, 16'h0);
            @(negedge clk_clk);
            chk($sformatf("t6.rd%0d.s_read", k), s_read, 1);
            chk($sformatf("t6.rd%0d.wait", k), (k == 1) ? m1_waitrequest : m0_waitrequest, 0);
        end

        @(posedge clk_clk); #1;
        drive(0, 0, 0, 0, 0, 0, 16'h0);
        reset_reset_n = 1'b0;
        @(negedge clk_clk);
        check_idle("t6.in_reset");
        chk("t6.in_reset.err_orphan", err_orphan, 0);
        @(posedge clk_clk); #1 reset_reset_n = 1'b1;

        for (int k = 0; k < 3; k++) begin
            @(posedge clk_clk); #1;
            drive(0, 0, 0, 0, 0, 1, 16'(16'h7000 + k));
            @(negedge clk_clk);
            chk($sformatf("t6.ret%0d.m0_rdv", k), m0_readdatavalid, 0);
            chk($sformatf("t6.ret%0d.m1_rdv", k), m1_readdatavalid, 0);
        end
        @(posedge clk_clk); #1;
        drive(0, 0, 0, 0, 0, 0, 16'h0);
        @(negedge clk_clk);
        chk("t6.err_orphan", err_orphan, 1);
        repeat (2) @(negedge clk_clk);
        chk("t6.err_sticky", err_orphan, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
